// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding and
// the byte counts of the fixed-size frame fields.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN   = 3'd0,
    ST_DATA  = 3'd1,
    ST_CSUM  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } loader_state_t;

  localparam int LEN_BYTES  = 4;
  localparam int WORD_BYTES = 4;

  // Index of the final byte of each multi-byte field, sized for the byte counter.
  localparam logic [1:0] LEN_LAST  = 2'(LEN_BYTES - 1);
  localparam logic [1:0] WORD_LAST = 2'(WORD_BYTES - 1);

endpackage

// File: rtl/inst_loader.sv
// Receives a length/words/checksum byte frame, writes each word to instruction
// SRAM, and releases the fetch stage only after a verified frame.
module inst_loader
  import loader_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  input  logic        load_req,
  output logic        inst_sram_wen,
  output logic [63:0] inst_sram_waddr,
  output logic [31:0] inst_sram_wdata,
  output logic        inst_sram_en_toif,
  output logic        load_done,
  output logic        load_err,
  output logic [31:0] words_loaded
);

  loader_state_t state, state_next;

  logic [1:0]  byte_cnt;
  logic [31:0] asm_word;
  logic [31:0] len_reg;
  logic [31:0] word_idx;
  logic [7:0]  xor_acc;

  logic        accept;
  logic [31:0] shifted_word;

  assign in_ready     = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
  assign accept       = in_valid && in_ready;
  // Bytes shift in from the top so the first byte of a field ends up in [7:0].
  assign shifted_word = {in_byte, asm_word[31:8]};
  assign words_loaded = word_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_LEN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_LEN: begin
        if (accept && (byte_cnt == LEN_LAST)) begin
          if (shifted_word > 32'(MAX_WORDS))  state_next = ST_ERROR;
          else if (shifted_word == 32'd0)     state_next = ST_CSUM;
          else                                state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept && (byte_cnt == WORD_LAST) && ((word_idx + 32'd1) == len_reg))
          state_next = ST_CSUM;
      end
      ST_CSUM: begin
        if (accept) state_next = (in_byte == xor_acc) ? ST_DONE : ST_ERROR;
      end
      ST_DONE, ST_ERROR: begin
        if (load_req) state_next = ST_LEN;
      end
      default: state_next = ST_LEN;
    endcase
  end

  // Status flags are registered from the next state so they track the FSM exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_sram_en_toif <= 1'b0;
      load_done         <= 1'b0;
      load_err          <= 1'b0;
    end else begin
      inst_sram_en_toif <= (state_next == ST_DONE);
      load_done         <= (state_next == ST_DONE);
      load_err          <= (state_next == ST_ERROR);
    end
  end

  // The write register is loaded only on a word boundary, so bytes arriving
  // during the strobe cycle land in asm_word without disturbing wdata.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt        <= 2'd0;
      asm_word        <= 32'd0;
      len_reg         <= 32'd0;
      word_idx        <= 32'd0;
      xor_acc         <= 8'd0;
      inst_sram_wen   <= 1'b0;
      inst_sram_waddr <= 64'd0;
      inst_sram_wdata <= 32'd0;
    end else begin
      inst_sram_wen <= 1'b0;
      case (state)
        ST_LEN: begin
          if (accept) begin
            asm_word <= shifted_word;
            byte_cnt <= byte_cnt + 2'd1;
            xor_acc  <= xor_acc ^ in_byte;
            if (byte_cnt == LEN_LAST) len_reg <= shifted_word;
          end
        end
        ST_DATA: begin
          if (accept) begin
            asm_word <= shifted_word;
            byte_cnt <= byte_cnt + 2'd1;
            xor_acc  <= xor_acc ^ in_byte;
            if (byte_cnt == WORD_LAST) begin
              inst_sram_wen   <= 1'b1;
              inst_sram_waddr <= BASE_ADDR + {30'd0, word_idx, 2'b00};
              inst_sram_wdata <= shifted_word;
              word_idx        <= word_idx + 32'd1;
            end
          end
        end
        ST_DONE, ST_ERROR: begin
          if (load_req) begin
            byte_cnt <= 2'd0;
            asm_word <= 32'd0;
            len_reg  <= 32'd0;
            word_idx <= 32'd0;
            xor_acc  <= 8'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
